updown_counter_param: RTL and testbench



---
 rtl/updown_pkg.sv | 16 +
 rtl/updown_next_calc.sv | 89 ++++++++
 rtl/updown_counter_param.sv | 114 +++++++++++
 tb/tb_updown_counter_param.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/updown_pkg.sv
// Shared types for the parameterised up/down counter: count modes and step direction.
package updown_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP   = 2'b00,
    MODE_SAT    = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

endpackage

// File: rtl/updown_next_calc.sv
// Combinational step rule: next value, next direction and boundary flag for one step.
module updown_next_calc
  import updown_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic [WIDTH-1:0] min_limit,
  input  logic [WIDTH-1:0] max_limit,
  input  mode_t            mode,
  input  dir_t             dir,
  output logic [WIDTH-1:0] next_value,
  output dir_t             next_dir,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic at_top;
  logic at_bot;
  logic span_ok;

  assign at_top  = value >= max_limit;
  assign at_bot  = value <= min_limit;
  assign span_ok = max_limit > min_limit;

  always_comb begin
    next_value = value;
    next_dir   = dir;
    tc         = 1'b0;
    case (mode)
      MODE_SAT: begin
        if (dir == DIR_UP) begin
          if (at_top) begin
            next_value = max_limit;
            tc         = 1'b1;
          end else begin
            next_value = value + ONE;
          end
        end else begin
          if (at_bot) begin
            next_value = min_limit;
            tc         = 1'b1;
          end else begin
            next_value = value - ONE;
          end
        end
      end
      // Reversal steps off the limit; a zero-width range pins the value to it.
      MODE_BOUNCE: begin
        if (dir == DIR_UP) begin
          if (at_top) begin
            next_dir   = DIR_DOWN;
            next_value = span_ok ? (max_limit - ONE) : max_limit;
            tc         = 1'b1;
          end else begin
            next_value = value + ONE;
          end
        end else begin
          if (at_bot) begin
            next_dir   = DIR_UP;
            next_value = span_ok ? (min_limit + ONE) : min_limit;
            tc         = 1'b1;
          end else begin
            next_value = value - ONE;
          end
        end
      end
      default: begin
        if (dir == DIR_UP) begin
          if (at_top) begin
            next_value = min_limit;
            tc         = 1'b1;
          end else begin
            next_value = value + ONE;
          end
        end else begin
          if (at_bot) begin
            next_value = max_limit;
            tc         = 1'b1;
          end else begin
            next_value = value - ONE;
          end
        end
      end
    endcase
  end

endmodule

// File: rtl/updown_counter_param.sv
// Up/down counter with programmable limits, wrap/saturate/bounce modes and parallel load.
// Optional step prescaler enabled by defining UPDOWN_PRESCALE_EN.
module updown_counter_param
  import updown_pkg::*;
#(
  parameter int unsigned    WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int unsigned    PRESCALE  = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             inst,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] min_limit,
  input  logic [WIDTH-1:0] max_limit,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] value,
  output logic             dir_out,
  output logic             at_max,
  output logic             at_min,
  output logic             tc_pulse,
  output logic             cfg_err
);

  mode_t            mode_e;
  logic             bounce;
  dir_t             dir_q;
  dir_t             eff_dir;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] calc_value;
  dir_t             calc_dir;
  logic             calc_tc;
  logic             step_en;

  assign mode_e  = mode_t'(mode);
  assign bounce  = (mode_e == MODE_BOUNCE);
  assign eff_dir = bounce ? dir_q : dir_t'(inst);

  assign dir_out = eff_dir;
  assign at_max  = (value == max_limit);
  assign at_min  = (value == min_limit);
  assign cfg_err = (min_limit > max_limit);

  assign load_clamped = (load_value < min_limit) ? min_limit :
                        (load_value > max_limit) ? max_limit : load_value;

  updown_next_calc #(
    .WIDTH(WIDTH)
  ) u_next_calc (
    .value      (value),
    .min_limit  (min_limit),
    .max_limit  (max_limit),
    .mode       (mode_e),
    .dir        (eff_dir),
    .next_value (calc_value),
    .next_dir   (calc_dir),
    .tc         (calc_tc)
  );

`ifdef UPDOWN_PRESCALE_EN
  localparam int unsigned        PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [PRE_W-1:0]   PRE_ONE  = PRE_W'(1);

  logic [PRE_W-1:0] pre_q;

  // Step only on the enabled cycle where the prescale count wraps to zero.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pre_q <= '0;
    end else if (!cfg_err) begin
      if (load) begin
        pre_q <= '0;
      end else if (enable) begin
        pre_q <= (pre_q == PRE_LAST) ? '0 : (pre_q + PRE_ONE);
      end
    end
  end

  assign step_en = enable && (pre_q == PRE_LAST);
`else
  logic unused_prescale;
  assign unused_prescale = ^PRESCALE;
  assign step_en         = enable;
`endif

  // Outside bounce the direction register shadows inst so a bounce sweep starts the same way.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      value    <= RESET_VAL;
      dir_q    <= DIR_UP;
      tc_pulse <= 1'b0;
    end else begin
      tc_pulse <= 1'b0;
      if (!bounce) begin
        dir_q <= dir_t'(inst);
      end
      if (!cfg_err) begin
        if (load) begin
          value <= load_clamped;
        end else if (step_en) begin
          value    <= calc_value;
          tc_pulse <= calc_tc;
          if (bounce) begin
            dir_q <= calc_dir;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: directed cases plus randomized traffic against an arithmetic model.
module tb_updown_counter_param;

  localparam int unsigned W  = 8;
  localparam int unsigned RV = 5;
`ifdef UPDOWN_PRESCALE_EN
  localparam int PS = 4;
`else
  localparam int PS = 1;
`endif

  logic         clock = 1'b0;
  logic         reset_n;
  logic         enable;
  logic         inst;
  logic [1:0]   mode;
  logic [W-1:0] min_limit;
  logic [W-1:0] max_limit;
  logic         load;
  logic [W-1:0] load_value;
  logic [W-1:0] value;
  logic         dir_out;
  logic         at_max;
  logic         at_min;
  logic         tc_pulse;
  logic         cfg_err;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int m_val;
  bit m_dir;
  bit m_tc;
  int m_pre;

  updown_counter_param #(
    .WIDTH    (W),
    .RESET_VAL(W'(RV)),
    .PRESCALE (4)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .enable    (enable),
    .inst      (inst),
    .mode      (mode),
    .min_limit (min_limit),
    .max_limit (max_limit),
    .load      (load),
    .load_value(load_value),
    .value     (value),
    .dir_out   (dir_out),
    .at_max    (at_max),
    .at_min    (at_min),
    .tc_pulse  (tc_pulse),
    .cfg_err   (cfg_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock edge of the counter, written directly from the behavioural rules.
  task automatic model_edge();
    int lo, hi, lv;
    bit bouncing, up;
    lo = int'(min_limit);
    hi = int'(max_limit);
    lv = int'(load_value);
    bouncing = (mode == 2'd2);
    if (!reset_n) begin
      m_val = RV; m_dir = 0; m_tc = 0; m_pre = 0;
      return;
    end
    m_tc = 0;
    if (!bouncing) m_dir = inst;
    if (lo > hi) return;
    if (load) begin
      m_val = (lv < lo) ? lo : (lv > hi) ? hi : lv;
      m_pre = 0;
      return;
    end
    if (!enable) return;
    m_pre = (m_pre + 1) % PS;
    if (m_pre != 0) return;
    up = bouncing ? !m_dir : !inst;
    if (mode == 2'd1) begin
      if (up) begin
        if (m_val >= hi) begin m_val = hi; m_tc = 1; end else m_val = m_val + 1;
      end else begin
        if (m_val <= lo) begin m_val = lo; m_tc = 1; end else m_val = m_val - 1;
      end
    end else if (bouncing) begin
      if (up) begin
        if (m_val >= hi) begin m_dir = 1; m_tc = 1; m_val = (hi > lo) ? hi - 1 : hi; end
        else m_val = m_val + 1;
      end else begin
        if (m_val <= lo) begin m_dir = 0; m_tc = 1; m_val = (hi > lo) ? lo + 1 : lo; end
        else m_val = m_val - 1;
      end
    end else begin
      if (up) begin
        if (m_val >= hi) begin m_val = lo; m_tc = 1; end else m_val = m_val + 1;
      end else begin
        if (m_val <= lo) begin m_val = hi; m_tc = 1; end else m_val = m_val - 1;
      end
    end
  endtask

  // Advance one cycle and compare every output with the model.
  task automatic tick();
    bit exp_dir;
    model_edge();
    @(posedge clock);
    #1;
    exp_dir = (mode == 2'd2) ? m_dir : inst;
    check("value", 32'(value), 32'(m_val));
    check("tc_pulse", 32'(tc_pulse), 32'(m_tc));
    check("dir_out", 32'(dir_out), 32'(exp_dir));
    check("at_max", 32'(at_max), 32'(m_val == int'(max_limit)));
    check("at_min", 32'(at_min), 32'(m_val == int'(min_limit)));
    check("cfg_err", 32'(cfg_err), 32'(min_limit > max_limit));
  endtask

  task automatic set_limits(input int lo, input int hi);
    min_limit = W'(lo);
    max_limit = W'(hi);
  endtask

  initial begin
    int sat_v[5];
    int sat_t[5];
    int bnc_v[8];
    int bnc_t[8];
    int tc_count;

    sat_v = '{19, 20, 20, 20, 20};
    sat_t = '{0, 0, 1, 1, 1};
    bnc_v = '{4, 5, 6, 5, 4, 3, 4, 5};
    bnc_t = '{0, 0, 0, 1, 0, 0, 1, 0};

    reset_n = 0; enable = 0; inst = 1; mode = 2'd2; load = 0; load_value = '0;
    set_limits(0, 255);
    m_val = 0; m_dir = 0; m_tc = 0; m_pre = 0;
    #2;

    // Reset state, with bounce mode selected so dir_out shows the direction register
    tick(); tick();
    check("rst_value", 32'(value), RV);
    check("rst_tc", 32'(tc_pulse), 0);
    check("rst_dir", 32'(dir_out), 0);

    // Full-range wrap from 0 returns to 0 with exactly one terminal pulse
    reset_n = 1; mode = 2'd0; inst = 0; load = 1; load_value = '0;
    tick();
    load = 0; enable = 1; tc_count = 0;
    repeat (256 * PS) begin
      tick();
      if (tc_pulse) tc_count++;
    end
    check("wrap_value", 32'(value), 0);
    check("wrap_tc_count", 32'(tc_count), 1);

    // Saturate at 20 from a load of 18
    set_limits(10, 20); mode = 2'd1; load = 1; load_value = W'(18); enable = 0;
    tick();
    load = 0; enable = 1;
    for (int i = 0; i < 5; i++) begin
      repeat (PS) tick();
      check("sat_value", 32'(value), 32'(sat_v[i]));
      check("sat_tc", 32'(tc_pulse), 32'(sat_t[i]));
    end

    // Bounce sweep 3..6; inst is randomized and must not matter
    set_limits(3, 6); mode = 2'd0; inst = 0; load = 1; load_value = W'(3); enable = 0;
    tick();
    load = 0; mode = 2'd2; enable = 1;
    for (int i = 0; i < 8; i++) begin
      repeat (PS) begin
        inst = 1'($urandom);
        tick();
      end
      check("bounce_value", 32'(value), 32'(bnc_v[i]));
      check("bounce_tc", 32'(tc_pulse), 32'(bnc_t[i]));
    end

    // Load clamping and priority
    set_limits(10, 20); mode = 2'd0; inst = 0; enable = 0; load = 1; load_value = W'(200);
    tick();
    check("load_clamp_hi", 32'(value), 20);
    load_value = W'(2);
    tick();
    check("load_clamp_lo", 32'(value), 10);
    enable = 1; load_value = W'(15);
    tick();
    check("load_over_enable", 32'(value), 15);
    check("load_tc", 32'(tc_pulse), 0);
    reset_n = 0; load_value = W'(12);
    tick();
    check("reset_over_load", 32'(value), RV);

    // Inverted limits freeze the counter
    reset_n = 1; load = 0; enable = 1; set_limits(30, 20);
    tc_count = 0;
    repeat (10) begin
      tick();
      if (tc_pulse) tc_count++;
    end
    check("cfg_err_flag", 32'(cfg_err), 1);
    check("cfg_hold_value", 32'(value), RV);
    check("cfg_tc_count", 32'(tc_count), 0);
    load = 1; load_value = W'(25);
    tick();
    check("cfg_load_blocked", 32'(value), RV);
    load = 0;

`ifdef UPDOWN_PRESCALE_EN
    // Four enabled cycles per step; a load restarts the spacing
    set_limits(0, 255); mode = 2'd0; inst = 0; load = 1; load_value = '0; enable = 0;
    tick();
    load = 0; enable = 1;
    repeat (12) tick();
    check("pre_value12", 32'(value), 3);
    repeat (2) tick();
    load = 1; load_value = W'(50);
    tick();
    load = 0;
    repeat (3) tick();
    check("pre_after_load3", 32'(value), 50);
    tick();
    check("pre_after_load4", 32'(value), 51);
`endif

    // Randomized traffic; limits only move together with a load
    reset_n = 1; load = 1; set_limits(10, 30); load_value = W'(15);
    tick();
    for (int i = 0; i < 3000; i++) begin
      int lo;
      reset_n = ($urandom_range(0, 199) != 0);
      enable  = ($urandom_range(0, 9) < 8);
      inst    = 1'($urandom);
      mode    = 2'($urandom);
      load    = ($urandom_range(0, 19) == 0);
      load_value = W'($urandom_range(0, 255));
      if ($urandom_range(0, 49) == 0) begin
        lo = $urandom_range(0, 60);
        if ($urandom_range(0, 9) == 0) set_limits(lo + 5, lo);
        else set_limits(lo, lo + $urandom_range(0, 12));
        load = 1;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
